// File: rtl/jump_target_table_if.sv
// Request/response bundle for jump_target_table: lookup request, table write port
// and the registered lookup result with stack status.
interface jump_target_table_if #(
    parameter int PTR_W     = 5,
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic              Req;
    logic [1:0]        Op;
    logic [PTR_W-1:0]  Jptr;
    logic [ADDR_W-1:0] RetAddr;
    logic              WrEn;
    logic [PTR_W-1:0]  WrPtr;
    logic [ADDR_W-1:0] WrData;
    logic [ADDR_W-1:0] Jump;
    logic              JumpValid;
    logic              Miss;
    logic              Ovf;
    logic              Unf;
    logic [CNT_W-1:0]  RasCount;

    modport master (
        output Req, Op, Jptr, RetAddr, WrEn, WrPtr, WrData,
        input  Jump, JumpValid, Miss, Ovf, Unf, RasCount
    );

    modport slave (
        input  Req, Op, Jptr, RetAddr, WrEn, WrPtr, WrData,
        output Jump, JumpValid, Miss, Ovf, Unf, RasCount
    );
endinterface

// File: rtl/jump_target_table.sv
// Jump target lookup table with a circular return-address stack; one-cycle
// registered result per request, write bypass on a same-index table write.
module jump_target_table #(
    parameter int PTR_W     = 5,
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    jump_target_table_if.slave bus
);
    localparam int ENTRIES = 1 << PTR_W;
    localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam int SP_W    = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        OP_JMP  = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    logic [ADDR_W-1:0] tbl_rd [ENTRIES];
    logic [ENTRIES-1:0] vld_rd;
    logic [ADDR_W-1:0] ras_rd [RAS_DEPTH];

    logic [ADDR_W-1:0] jump_q, jump_d;
    logic              jv_q, jv_d;
    logic              miss_q, miss_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_en;

    op_e               op;
    logic              bypass;
    logic [ADDR_W-1:0] lookup_target;
    logic              lookup_miss;

    // Table entries are plain flops so reset can clear every target and valid bit.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_tbl
        logic [ADDR_W-1:0] ent_q, ent_d;
        logic              ent_vld_q, ent_vld_d;

        always_comb begin
            ent_d     = ent_q;
            ent_vld_d = ent_vld_q;
            if (bus.WrEn && (bus.WrPtr == PTR_W'(gi))) begin
                ent_d     = bus.WrData;
                ent_vld_d = 1'b1;
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                ent_q     <= '0;
                ent_vld_q <= 1'b0;
            end else begin
                ent_q     <= ent_d;
                ent_vld_q <= ent_vld_d;
            end
        end

        assign tbl_rd[gi] = ent_q;
        assign vld_rd[gi] = ent_vld_q;
    end

    // sp_q is the next free slot; when full it also points at the oldest entry,
    // so an overflowing push overwrites the oldest without extra logic.
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
        logic [ADDR_W-1:0] slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (push_en && (sp_q == SP_W'(gi))) begin
                slot_d = bus.RetAddr;
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign ras_rd[gi] = slot_q;
    end

    assign op            = op_e'(bus.Op);
    assign bypass        = bus.WrEn && (bus.WrPtr == bus.Jptr);
    assign lookup_target = bypass ? bus.WrData : tbl_rd[bus.Jptr];
    assign lookup_miss   = bypass ? 1'b0 : ~vld_rd[bus.Jptr];

    always_comb begin
        jump_d  = jump_q;
        jv_d    = 1'b0;
        miss_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        if (bus.Req) begin
            jv_d = 1'b1;
            case (op)
                OP_JMP: begin
                    jump_d = lookup_target;
                    miss_d = lookup_miss;
                end
                OP_CALL: begin
                    jump_d  = lookup_target;
                    miss_d  = lookup_miss;
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (cnt_q != '0) begin
                        jump_d = ras_rd[sp_q - SP_W'(1)];
                        sp_d   = sp_q - SP_W'(1);
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        jump_d = '0;
                        unf_d  = 1'b1;
                    end
                end
                default: begin
                    jump_d = '0;
                    miss_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            jump_q <= '0;
            jv_q   <= 1'b0;
            miss_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            sp_q   <= '0;
            cnt_q  <= '0;
        end else begin
            jump_q <= jump_d;
            jv_q   <= jv_d;
            miss_q <= miss_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Jump      = jump_q;
    assign bus.JumpValid = jv_q;
    assign bus.Miss      = miss_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Unf       = unf_q;
    assign bus.RasCount  = cnt_q;
endmodule

// File: tb/tb_jump_target_table.sv
// Directed bench for jump_target_table: each task drives one scenario and
// compares the full output tuple {Jump,JumpValid,Miss,Ovf,Unf,RasCount}.
module tb_jump_target_table;
    localparam int PTR_W     = 5;
    localparam int ADDR_W    = 12;
    localparam int RAS_DEPTH = 4;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    jump_target_table_if #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    jump_target_table #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [18:0] obs;
    assign obs = {bus.Jump, bus.JumpValid, bus.Miss, bus.Ovf, bus.Unf, bus.RasCount};

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [18:0] ev(input logic [11:0] j, input logic jv, input logic miss,
                                       input logic ovf, input logic unf, input logic [2:0] cnt);
        return {j, jv, miss, ovf, unf, cnt};
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [1:0] op, input logic [4:0] jptr,
                         input logic [11:0] ra);
        bus.Req     = req;
        bus.Op      = op;
        bus.Jptr    = jptr;
        bus.RetAddr = ra;
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        bus.WrEn   = 1'b0;
        bus.WrPtr  = '0;
        bus.WrData = '0;
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        #3;
        n_cmp++;
        if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
        end
        cycle(); cycle();
        Reset_n = 1'b1;
        cycle();
        n_cmp++;
        if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
        end
        $display("test_reset done");
    endtask

    task automatic test_jmp_miss();
        drive(1'b1, 2'b00, 5'd3, 12'h000);
        cycle();
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        n_cmp++;
        if (obs !== ev(12'h000, 1, 1, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL jmp_unwritten: got %h expected %h", obs, ev(12'h000, 1, 1, 0, 0, 3'd0));
        end
        cycle();
        n_cmp++;
        if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL jmp_idle_after: got %h expected %h", obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
        end
        $display("test_jmp_miss done");
    endtask

    task automatic test_bypass();
        bus.WrEn = 1'b1; bus.WrPtr = 5'd4; bus.WrData = 12'h0F2;
        drive(1'b1, 2'b00, 5'd4, 12'h000);
        cycle();
        bus.WrEn = 1'b0;
        n_cmp++;
        if (obs !== ev(12'h0F2, 1, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL bypass_same_edge: got %h expected %h", obs, ev(12'h0F2, 1, 0, 0, 0, 3'd0));
        end
        cycle();
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        n_cmp++;
        if (obs !== ev(12'h0F2, 1, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL bypass_stored: got %h expected %h", obs, ev(12'h0F2, 1, 0, 0, 0, 3'd0));
        end
        cycle();
        n_cmp++;
        if (obs !== ev(12'h0F2, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL idle_holds_jump: got %h expected %h", obs, ev(12'h0F2, 0, 0, 0, 0, 3'd0));
        end
        $display("test_bypass done");
    endtask

    task automatic test_ras();
        logic [18:0] e;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 2'b01, 5'd4, 12'(i));
            cycle();
            e = ev(12'h0F2, 1, 0, (i == 5), 0, (i > 4) ? 3'd4 : 3'(i));
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL ras_call%0d: got %h expected %h", i, obs, e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b10, 5'd0, 12'h000);
            cycle();
            e = ev(12'(5 - k), 1, 0, 0, 0, 3'(3 - k));
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL ras_ret%0d: got %h expected %h", k + 1, obs, e);
            end
        end
        cycle();
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        n_cmp++;
        if (obs !== ev(12'h000, 1, 0, 0, 1, 3'd0)) begin
            n_fail++; $display("FAIL ras_underflow: got %h expected %h", obs, ev(12'h000, 1, 0, 0, 1, 3'd0));
        end
        $display("test_ras done");
    endtask

    task automatic test_reserved();
        logic [18:0] e [5];
        e[0] = ev(12'h000, 1, 1, 0, 0, 3'd1);
        e[1] = ev(12'h0F2, 1, 0, 0, 0, 3'd2);
        e[2] = ev(12'h000, 1, 1, 0, 0, 3'd2);
        e[3] = ev(12'h00B, 1, 0, 0, 0, 3'd1);
        e[4] = ev(12'h00A, 1, 0, 0, 0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 2'b01, 5'd7, 12'h00A);
                1: drive(1'b1, 2'b01, 5'd4, 12'h00B);
                2: drive(1'b1, 2'b11, 5'd4, 12'h000);
                default: drive(1'b1, 2'b10, 5'd0, 12'h000);
            endcase
            cycle();
            n_cmp++;
            if (obs !== e[i]) begin
                n_fail++; $display("FAIL reserved_step%0d: got %h expected %h", i, obs, e[i]);
            end
        end
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        $display("test_reserved done");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops  [8] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
        logic [4:0]  ptrs [8] = '{5'd9, 5'd4, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10};
        logic [11:0] ras  [8] = '{12'h111, 12'h000, 12'h222, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        logic [18:0] e    [8];
        e[0] = ev(12'h123, 1, 0, 0, 0, 3'd1);
        e[1] = ev(12'h0F2, 1, 0, 0, 0, 3'd1);
        e[2] = ev(12'h000, 1, 1, 0, 0, 3'd2);
        e[3] = ev(12'h222, 1, 0, 0, 0, 3'd1);
        e[4] = ev(12'h000, 1, 1, 0, 0, 3'd1);
        e[5] = ev(12'h111, 1, 0, 0, 0, 3'd0);
        e[6] = ev(12'h000, 1, 0, 0, 1, 3'd0);
        e[7] = ev(12'h3AB, 1, 0, 0, 0, 3'd0);
        bus.WrEn = 1'b1; bus.WrPtr = 5'd9; bus.WrData = 12'h123;
        cycle();
        bus.WrEn = 1'b0;
        n_cmp++;
        if (obs !== ev(12'h00A, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL b2b_preload: got %h expected %h", obs, ev(12'h00A, 0, 0, 0, 0, 3'd0));
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], ptrs[i], ras[i]);
            bus.WrEn = (i == 7); bus.WrPtr = 5'd10; bus.WrData = 12'h3AB;
            cycle();
            n_cmp++;
            if (obs !== e[i]) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs, e[i]);
            end
        end
        bus.WrEn = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        cycle();
        n_cmp++;
        if (obs !== ev(12'h3AB, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL b2b_end_idle: got %h expected %h", obs, ev(12'h3AB, 0, 0, 0, 0, 3'd0));
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        logic [18:0] e;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b01, 5'd4, 12'h050);
            cycle();
            e = ev(12'h0F2, 1, 0, 0, 0, 3'(i));
            n_cmp++;
            if (obs !== e) begin
                n_fail++; $display("FAIL midrst_call%0d: got %h expected %h", i, obs, e);
            end
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL midrst_immediate: got %h expected %h", obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
        end
        cycle();
        n_cmp++;
        if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL midrst_held: got %h expected %h", obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
        end
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        Reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (obs !== ev(12'h000, 0, 0, 0, 0, 3'd0)) begin
                n_fail++; $display("FAIL midrst_release%0d: got %h expected %h", i, obs, ev(12'h000, 0, 0, 0, 0, 3'd0));
            end
        end
        drive(1'b1, 2'b00, 5'd4, 12'h000);
        cycle();
        drive(1'b0, 2'b00, 5'd0, 12'h000);
        n_cmp++;
        if (obs !== ev(12'h000, 1, 1, 0, 0, 3'd0)) begin
            n_fail++; $display("FAIL midrst_table_cleared: got %h expected %h", obs, ev(12'h000, 1, 1, 0, 0, 3'd0));
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_jmp_miss();
        test_bypass();
        test_ras();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jump_target_table.md
JUMP_TARGET_TABLE -- requirements
Module: jump_target_table

Interface
REQ-001 The block SHALL have parameter PTR_W, default 5, meaning pointer width; the table holds 2^PTR_W entries.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning jump-target width.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack depth; legal values are powers of two, at least 2.
REQ-004 The block SHALL have port Clk  in  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port Req  in  1  lookup request valid.
REQ-007 The block SHALL have port Op  in  2  request kind: 00 JMP, 01 CALL, 10 RET, 11 reserved.
REQ-008 The block SHALL have port Jptr  in  PTR_W  table index for JMP/CALL.
REQ-009 The block SHALL have port RetAddr  in  ADDR_W  return address pushed on CALL.
REQ-010 The block SHALL have port WrEn  in  1  table write strobe.
REQ-011 The block SHALL have port WrPtr  in  PTR_W  table write index.
REQ-012 The block SHALL have port WrData  in  ADDR_W  table write data.
REQ-013 The block SHALL have port Jump  out  ADDR_W  registered jump target.
REQ-014 The block SHALL have port JumpValid  out  1  one-cycle pulse marking Jump as new.
REQ-015 The block SHALL have port Miss  out  1  target came from an unwritten entry or a reserved Op.
REQ-016 The block SHALL have port Ovf  out  1  CALL overwrote the oldest stack entry.
REQ-017 The block SHALL have port Unf  out  1  RET issued with an empty stack.
REQ-018 The block SHALL have port RasCount  out  $clog2(RAS_DEPTH+1)  current stack occupancy.

Function
REQ-019 The table SHALL hold an ADDR_W target and a valid bit per entry; WrEn at an edge SHALL store WrData at WrPtr and set that entry's valid bit.
REQ-020 Latency SHALL be one cycle: a request sampled at edge N drives Jump/JumpValid/Miss/Ovf/Unf after edge N, and a new request SHALL be accepted every cycle.
REQ-021 With Req=0 at an edge, JumpValid, Miss, Ovf and Unf SHALL be 0 for the following cycle, and Jump SHALL hold its previous value.
REQ-022 JMP SHALL return Jump=table[Jptr] and Miss=~valid[Jptr]; an unwritten entry SHALL read as 0.
REQ-023 If WrEn and Req hit the same index at the same edge, the lookup SHALL return WrData with Miss=0 (write bypass).
REQ-024 CALL SHALL return as JMP and push RetAddr; when RasCount=RAS_DEPTH, the push SHALL overwrite the oldest entry with RasCount unchanged and Ovf=1.
REQ-025 RET with RasCount>0 SHALL return Jump=top of stack, pop it and decrement RasCount, with Miss=0.
REQ-026 RET with RasCount=0 SHALL return Jump=0 and Unf=1, and the stack SHALL be unchanged.
REQ-027 Op=11 SHALL return Jump=0, Miss=1 and JumpValid=1 with no stack change.
REQ-028 Stack pointers SHALL wrap modulo RAS_DEPTH, and the table write SHALL be independent of Op.

Reset
REQ-029 Reset_n=0 SHALL asynchronously clear all table entries and valid bits, empty the stack (RasCount=0), and drive Jump=0, JumpValid=0, Miss=0, Ovf=0 and Unf=0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight request, so that no JumpValid pulse occurs after Reset_n deasserts until a new Req.

Verification
REQ-031 Reset, then Req JMP Jptr=3 -> next cycle Jump=0, Miss=1, JumpValid=1.
REQ-032 WrEn WrPtr=4 WrData=12'h0F2 with the same-edge Req JMP Jptr=4 -> Jump=12'h0F2, Miss=0; then Req JMP Jptr=4 alone -> same result.
REQ-033 Default parameters: five CALLs with RetAddr 1..5 -> fifth gives Ovf=1 and RasCount=4; four RETs -> Jump=5,4,3,2, then a fifth RET -> Jump=0, Unf=1, RasCount=0.
REQ-034 Back-to-back Req every cycle for 8 cycles with mixed Op -> JumpValid high for 8 consecutive cycles, each result matching a model.
REQ-035 Assert Reset_n low during a stream of CALLs -> RasCount=0, all outputs 0 immediately, no JumpValid after release until the next Req.
REQ-036 Op=11 with RasCount=2 -> Jump=0, Miss=1, RasCount stays 2.
